seg7_scan_2digit: RTL

// - Drives a 2-digit multiplexed common-anode 7-segment display from the BCD pair
//   (chuc = tens, donvi = units) produced by the 7-bit hex-to-BCD converter.
// - Digits are double-buffered so a frame never shows mixed old/new values.
// - Features: guard blanking between digits, optional leading-zero blanking,

---
 rtl/seg7_scan_2digit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_2digit.sv
// Two-digit multiplexed common-anode 7-segment driver.
// Scans units then tens with optional all-off guard slots, double-buffers the
// BCD digits per frame, supports leading-zero blanking, whole-display blink and
// a dash glyph for nibbles above 9. All outputs are registered.
module seg7_scan_2digit #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 16,
  parameter int BLINK_DIV   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] chuc,
  input  logic [3:0] donvi,
  input  logic       load,
  input  logic       lz_blank,
  input  logic       blink_en,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       frame_st
);

  localparam int SLOT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CW       = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int FW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GRD_LAST = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [FW-1:0] BLK_LAST = FW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {S_D0, S_G0, S_D1, S_G1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          armed;        // low only in the cycle(s) right after reset release
  logic          frame_nx;     // next cycle is the first cycle of a frame
  logic [3:0]    pend_tens, pend_units;
  logic          pend_lz;
  logic [3:0]    sh_tens, sh_units, sh_tens_nx, sh_units_nx;
  logic          sh_lz, sh_lz_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  logic          phase, phase_nx;
  logic [1:0]    an_nx;
  logic [6:0]    seg_nx;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h3F;  // dash for non-BCD nibbles
    endcase
    return g;
  endfunction

  // Next scan state, slot count, shadow digits, blink phase and output values.
  // The outputs are computed from the *next* state so that they change on the
  // same edge the FSM enters a state.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nx    = state;
    cnt_nx      = cnt + CW'(1);
    frame_nx    = 1'b0;
    sh_tens_nx  = sh_tens;
    sh_units_nx = sh_units;
    sh_lz_nx    = sh_lz;
    fcnt_nx     = fcnt;
    phase_nx    = phase;
    an_nx       = 2'b11;
    seg_nx      = 7'h7F;

    if (!armed) begin
      // First edge after reset release opens frame 0 in S_D0.
      state_nx = S_D0;
      cnt_nx   = '0;
      frame_nx = 1'b1;
    end else begin
      case (state)
        S_D0: if (cnt == REF_LAST) begin
          cnt_nx   = '0;
          state_nx = (GUARD_CYC > 0) ? S_G0 : S_D1;
        end
        S_G0: if (cnt == GRD_LAST) begin
          cnt_nx   = '0;
          state_nx = S_D1;
        end
        S_D1: if (cnt == REF_LAST) begin
          cnt_nx = '0;
          if (GUARD_CYC > 0) begin
            state_nx = S_G1;
          end else begin
            state_nx = S_D0;
            frame_nx = 1'b1;
          end
        end
        S_G1: if (cnt == GRD_LAST) begin
          cnt_nx   = '0;
          state_nx = S_D0;
          frame_nx = 1'b1;
        end
        default: begin
          cnt_nx   = '0;
          state_nx = S_D0;
        end
      endcase

      // A frame just completed: advance the blink divider.
      if (frame_nx) begin
        if (fcnt == BLK_LAST) begin
          fcnt_nx  = '0;
          phase_nx = ~phase;
        end else begin
          fcnt_nx = fcnt + FW'(1);
        end
      end
    end

    // Frame start takes the pending digits; a load on that same edge is
    // forwarded so it is not lost behind the copy.
    if (frame_nx) begin
      sh_tens_nx  = load ? chuc     : pend_tens;
      sh_units_nx = load ? donvi    : pend_units;
      sh_lz_nx    = load ? lz_blank : pend_lz;
    end

    case (state_nx)
      S_D0: begin
        an_nx  = 2'b10;
        seg_nx = glyph(sh_units_nx);
      end
      S_D1: if (!(sh_lz_nx && sh_tens_nx == 4'd0)) begin
        an_nx  = 2'b01;
        seg_nx = glyph(sh_tens_nx);
      end
      default: ;
    endcase

    // Blink only gates the anodes; scan timing keeps running underneath.
    if (blink_en && phase_nx) an_nx = 2'b11;
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_D0;
      cnt        <= '0;
      armed      <= 1'b0;
      pend_tens  <= '0;
      pend_units <= '0;
      pend_lz    <= 1'b0;
      sh_tens    <= '0;
      sh_units   <= '0;
      sh_lz      <= 1'b0;
      fcnt       <= '0;
      phase      <= 1'b0;
      an         <= 2'b11;
      seg        <= 7'h7F;
      frame_st   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_nx;
      cnt      <= cnt_nx;
      armed    <= 1'b1;
      sh_tens  <= sh_tens_nx;
      sh_units <= sh_units_nx;
      sh_lz    <= sh_lz_nx;
      fcnt     <= fcnt_nx;
      phase    <= phase_nx;
      an       <= an_nx;
      seg      <= seg_nx;
      frame_st <= frame_nx;
      if (load) begin
        pend_tens  <= chuc;
        pend_units <= donvi;
        pend_lz    <= lz_blank;
      end
    end
  end

endmodule
